wb_stage: RTL and testbench

- Write-back stage. It is the producer side of the decode stage's register-file write port (wb_waddr / wb_wdata / wb_wena).
- Holds the MEM/WB pipeline register and selects ALU result or load data for write-back.
- Drives exactly one register-file write per retired instruction.
- Provides same-cycle write-to-read bypass for decode's two operand reads, plus retire and bypass counters for debug.

---
 rtl/wb_stage.sv | 136 +++++++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- pipeline write-back stage
//
// Holds the MEM/WB pipeline register. It drives the register-file write port,
// bypasses a same-cycle write to decode's two operand reads, and keeps
// saturating retire/bypass counters for debug.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   mem_*               instruction leaving MEM (valid, wreg enable, dest
//                       address, ALU result, load data, load select)
//   stall, flush        hold / invalidate the MEM/WB register (flush wins)
//   id_r1addr/id_r2addr decode read addresses
//   id_r1data_rf/_r2    raw register-file read data
//   wb_waddr/wdata/wena register-file write port
//   fwd_r1data/_r2data  operands after the write-to-read bypass
//   retire_cnt          number of instructions that left WB (saturating)
//   bypass_cnt          number of cycles with at least one bypass hit
//                       (saturating)
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int CW       = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic          mem_wreg_en,
  input  logic [AW-1:0] mem_wreg_addr,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_to_reg,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] id_r1addr,
  input  logic [AW-1:0] id_r2addr,
  input  logic [DW-1:0] id_r1data_rf,
  input  logic [DW-1:0] id_r2data_rf,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_wena,
  output logic [DW-1:0] fwd_r1data,
  output logic [DW-1:0] fwd_r2data,
  output logic [CW-1:0] retire_cnt,
  output logic [CW-1:0] bypass_cnt
);

  logic          valid_q,   valid_d;
  logic          wreg_en_q, wreg_en_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [DW-1:0] data_q,    data_d;
  logic          written_q, written_d;
  logic [CW-1:0] retire_cnt_q, retire_cnt_d;
  logic [CW-1:0] bypass_cnt_q, bypass_cnt_d;

  logic          zero_target;
  logic          hit1;
  logic          hit2;
  logic          retire_inc;
  logic          bypass_inc;

  // Write port and bypass
  always_comb begin
    zero_target = (ZERO_REG != 0) && (addr_q == '0);
    // written_q marks an entry that already wrote during an earlier stall
    // cycle; it must not write (or bypass) again.
    wb_wena     = valid_q & wreg_en_q & ~written_q & ~zero_target;
    wb_waddr    = addr_q;
    wb_wdata    = data_q;

    hit1        = wb_wena && (id_r1addr == addr_q);
    hit2        = wb_wena && (id_r2addr == addr_q);
    fwd_r1data  = hit1 ? data_q : id_r1data_rf;
    fwd_r2data  = hit2 ? data_q : id_r2data_rf;
  end

  // MEM/WB register next state: flush > stall > capture
  always_comb begin
    valid_d   = valid_q;
    wreg_en_d = wreg_en_q;
    addr_d    = addr_q;
    data_d    = data_q;
    written_d = written_q;

    if (flush) begin
      valid_d   = 1'b0;
      written_d = 1'b0;
    end else if (stall) begin
      written_d = written_q | wb_wena;
    end else begin
      valid_d   = mem_valid;
      wreg_en_d = mem_wreg_en;
      addr_d    = mem_wreg_addr;
      data_d    = mem_to_reg ? mem_rdata : mem_alu_result;
      written_d = 1'b0;
    end
  end

  // Saturating debug counters
  always_comb begin
    retire_inc   = valid_q & ~stall & ~flush;
    bypass_inc   = hit1 | hit2;
    retire_cnt_d = retire_cnt_q;
    bypass_cnt_d = bypass_cnt_q;
    if (retire_inc && (retire_cnt_q != '1))
      retire_cnt_d = retire_cnt_q + CW'(1);
    if (bypass_inc && (bypass_cnt_q != '1))
      bypass_cnt_d = bypass_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      wreg_en_q    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      written_q    <= 1'b0;
      retire_cnt_q <= '0;
      bypass_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      wreg_en_q    <= wreg_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      written_q    <= written_d;
      retire_cnt_q <= retire_cnt_d;
      bypass_cnt_q <= bypass_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign bypass_cnt = bypass_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam logic [31:0] RF1 = 32'hAAAA5555;
  localparam logic [31:0] RF2 = 32'h5A5A5A5A;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_wreg_en, mem_to_reg, stall, flush;
  logic [4:0]  mem_wreg_addr, id_r1addr, id_r2addr;
  logic [31:0] mem_alu_result, mem_rdata, id_r1data_rf, id_r2data_rf;

  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, fwd_r1data, fwd_r2data, retire_cnt, bypass_cnt;
  logic        wb_wena;

  logic [4:0]  s_waddr;
  logic [31:0] s_wdata, s_fwd1, s_fwd2;
  logic        s_wena;
  logic [3:0]  s_retire, s_bypass;

  int checks = 0;
  int errors = 0;

  wb_stage #(.DW(32), .AW(5), .CW(32), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wreg_en(mem_wreg_en), .mem_wreg_addr(mem_wreg_addr),
    .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata), .mem_to_reg(mem_to_reg),
    .stall(stall), .flush(flush),
    .id_r1addr(id_r1addr), .id_r2addr(id_r2addr),
    .id_r1data_rf(id_r1data_rf), .id_r2data_rf(id_r2data_rf),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wena(wb_wena),
    .fwd_r1data(fwd_r1data), .fwd_r2data(fwd_r2data),
    .retire_cnt(retire_cnt), .bypass_cnt(bypass_cnt)
  );

  // Narrow-counter build, sharing stimulus, for saturation checks
  wb_stage #(.DW(32), .AW(5), .CW(4), .ZERO_REG(1)) u_dut4 (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wreg_en(mem_wreg_en), .mem_wreg_addr(mem_wreg_addr),
    .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata), .mem_to_reg(mem_to_reg),
    .stall(stall), .flush(flush),
    .id_r1addr(id_r1addr), .id_r2addr(id_r2addr),
    .id_r1data_rf(id_r1data_rf), .id_r2data_rf(id_r2data_rf),
    .wb_waddr(s_waddr), .wb_wdata(s_wdata), .wb_wena(s_wena),
    .fwd_r1data(s_fwd1), .fwd_r2data(s_fwd2),
    .retire_cnt(s_retire), .bypass_cnt(s_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, we;
    logic [4:0]  addr;
    logic [31:0] alu, rd;
    logic        m2r, stl, fl;
    logic [4:0]  r1a, r2a;
    logic [31:0] r1d, r2d;
    logic        e_wena;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_f1, e_f2, e_ret, e_byp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_valid = 0; mem_wreg_en = 0; mem_wreg_addr = 0;
    mem_alu_result = 0; mem_rdata = 0; mem_to_reg = 0;
    stall = 0; flush = 0;
  endtask

  task automatic drive_entry(input logic [4:0] a, input logic [31:0] d);
    mem_valid = 1; mem_wreg_en = 1; mem_wreg_addr = a;
    mem_alu_result = d; mem_rdata = 32'hFFFF0000; mem_to_reg = 0;
    stall = 0; flush = 0;
  endtask

  initial begin
    // Expected values: each vector is checked just before the clock edge
    // that captures it, so outputs reflect the previous vectors' entry.
    //          v  we addr  alu           rd          m2r st fl r1a r2a rf1   rf2   | wena waddr wdata         f1            f2    ret byp
    vecs[0] = '{0, 0, 5'd0, 32'h0,        32'h0,      0, 0, 0, 5'd1, 5'd2, RF1, RF2, 0, 5'd0, 32'h0,        RF1,          RF2,          0, 0};
    vecs[1] = '{1, 1, 5'd7, 32'h10,       32'h20,     0, 0, 0, 5'd1, 5'd2, RF1, RF2, 0, 5'd0, 32'h0,        RF1,          RF2,          0, 0};
    vecs[2] = '{1, 1, 5'd7, 32'h11,       32'h20,     1, 0, 0, 5'd7, 5'd2, RF1, RF2, 1, 5'd7, 32'h10,       32'h10,       RF2,          0, 0};
    vecs[3] = '{1, 1, 5'd3, 32'hDEAD,     32'h0,      0, 0, 0, 5'd1, 5'd2, RF1, RF2, 1, 5'd7, 32'h20,       RF1,          RF2,          1, 1};
    vecs[4] = '{1, 1, 5'd0, 32'h1234,     32'h0,      0, 0, 0, 5'd3, 5'd3, 0,   0,   1, 5'd3, 32'hDEAD,     32'hDEAD,     32'hDEAD,     2, 1};
    vecs[5] = '{0, 0, 5'd0, 32'h0,        32'h0,      0, 0, 0, 5'd0, 5'd0, RF1, RF2, 0, 5'd0, 32'h1234,     RF1,          RF2,          3, 2};
    vecs[6] = '{1, 0, 5'd9, 32'h77,       32'h0,      0, 0, 0, 5'd9, 5'd9, RF1, RF2, 0, 5'd0, 32'h0,        RF1,          RF2,          4, 2};
    vecs[7] = '{0, 0, 5'd0, 32'h0,        32'h0,      0, 0, 0, 5'd9, 5'd2, RF1, RF2, 0, 5'd9, 32'h77,       RF1,          RF2,          4, 2};
    vecs[8] = '{0, 0, 5'd0, 32'h0,        32'h0,      0, 0, 0, 5'd1, 5'd2, RF1, RF2, 0, 5'd0, 32'h0,        RF1,          RF2,          5, 2};

    rst = 0;
    drive_idle();
    id_r1addr = 0; id_r2addr = 0; id_r1data_rf = RF1; id_r2data_rf = RF2;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wena",   wb_wena,    0);
    chk("rst_waddr",  wb_waddr,   0);
    chk("rst_wdata",  wb_wdata,   0);
    chk("rst_fwd1",   fwd_r1data, RF1);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_bypass", bypass_cnt, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rel_wena", wb_wena,    0);
    chk("rel_fwd1", fwd_r1data, RF1);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_valid = vecs[i].v; mem_wreg_en = vecs[i].we; mem_wreg_addr = vecs[i].addr;
      mem_alu_result = vecs[i].alu; mem_rdata = vecs[i].rd; mem_to_reg = vecs[i].m2r;
      stall = vecs[i].stl; flush = vecs[i].fl;
      id_r1addr = vecs[i].r1a; id_r2addr = vecs[i].r2a;
      id_r1data_rf = vecs[i].r1d; id_r2data_rf = vecs[i].r2d;
      #1;
      chk($sformatf("v%0d_wena", i),   wb_wena,    vecs[i].e_wena);
      chk($sformatf("v%0d_waddr", i),  wb_waddr,   vecs[i].e_waddr);
      chk($sformatf("v%0d_wdata", i),  wb_wdata,   vecs[i].e_wdata);
      chk($sformatf("v%0d_fwd1", i),   fwd_r1data, vecs[i].e_f1);
      chk($sformatf("v%0d_fwd2", i),   fwd_r2data, vecs[i].e_f2);
      chk($sformatf("v%0d_retire", i), retire_cnt, vecs[i].e_ret);
      chk($sformatf("v%0d_bypass", i), bypass_cnt, vecs[i].e_byp);
    end
    id_r1data_rf = RF1; id_r2data_rf = RF2;

    // Stall for 3 cycles: single write, retire only when released
    @(negedge clk);
    drive_entry(5'd5, 32'h55);
    id_r1addr = 5'd5; id_r2addr = 5'd1;
    @(negedge clk);
    drive_entry(5'd6, 32'h66);
    stall = 1;
    #1;
    chk("stl1_wena",   wb_wena,    1);
    chk("stl1_waddr",  wb_waddr,   5);
    chk("stl1_wdata",  wb_wdata,   32'h55);
    chk("stl1_fwd1",   fwd_r1data, 32'h55);
    chk("stl1_retire", retire_cnt, 5);
    @(negedge clk);
    #1;
    chk("stl2_wena",   wb_wena,    0);
    chk("stl2_waddr",  wb_waddr,   5);
    chk("stl2_fwd1",   fwd_r1data, RF1);
    chk("stl2_retire", retire_cnt, 5);
    chk("stl2_bypass", bypass_cnt, 3);
    @(negedge clk);
    #1;
    chk("stl3_wena",   wb_wena,    0);
    chk("stl3_retire", retire_cnt, 5);
    @(negedge clk);
    drive_idle();
    #1;
    chk("stl_rel_wena",   wb_wena,    0);
    chk("stl_rel_retire", retire_cnt, 5);
    @(negedge clk);
    #1;
    chk("stl_done_retire", retire_cnt, 6);
    chk("stl_done_bypass", bypass_cnt, 3);

    // Flush together with stall: flush wins, no retire
    id_r1addr = 5'd1; id_r2addr = 5'd2;
    drive_entry(5'd8, 32'h88);
    @(negedge clk);
    stall = 1; flush = 1;
    #1;
    chk("fl_pre_wena",   wb_wena,    1);
    chk("fl_pre_retire", retire_cnt, 6);
    @(negedge clk);
    drive_idle();
    #1;
    chk("fl_wena",   wb_wena,    0);
    chk("fl_retire", retire_cnt, 6);
    @(negedge clk);
    #1;
    chk("fl_after_retire", retire_cnt, 6);
    chk("fl_after_bypass", bypass_cnt, 3);

    // Reset in the middle of a stall
    drive_entry(5'd4, 32'h44);
    id_r1addr = 5'd4;
    @(negedge clk);
    stall = 1;
    rst = 0;
    #1;
    chk("mrst_wena",   wb_wena,    0);
    chk("mrst_waddr",  wb_waddr,   0);
    chk("mrst_wdata",  wb_wdata,   0);
    chk("mrst_fwd1",   fwd_r1data, RF1);
    chk("mrst_retire", retire_cnt, 0);
    chk("mrst_bypass", bypass_cnt, 0);
    chk("mrst_retire4", s_retire,  0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("mrst_held_wena", wb_wena, 0);
    drive_idle();
    @(negedge clk);
    #1;
    chk("mrst_idle_wena",   wb_wena,    0);
    chk("mrst_idle_retire", retire_cnt, 0);
    chk("mrst_idle_bypass", bypass_cnt, 0);

    // 20 back-to-back writes to r2 with r2 being read: both counters
    // reach 20 on the wide build and saturate at 4'hF on the narrow one.
    id_r1addr = 5'd2; id_r2addr = 5'd9;
    for (int i = 0; i < 20; i++) begin
      drive_entry(5'd2, 32'(i + 100));
      @(negedge clk);
    end
    drive_idle();
    #1;
    chk("sat_mid_retire4", s_retire, 4'hF);
    @(negedge clk);
    #1;
    chk("sat_retire",  retire_cnt, 20);
    chk("sat_bypass",  bypass_cnt, 20);
    chk("sat_retire4", s_retire,   4'hF);
    chk("sat_bypass4", s_bypass,   4'hF);
    @(negedge clk);
    #1;
    chk("sat_hold_retire4", s_retire, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
